wb_slave_router: RTL and testbench

WB_SLAVE_ROUTER -- requirements
Module: wb_slave_router

---
 rtl/wb_slave_router.sv | 232 +++++++++++++++++++++++
 tb/tb_wb_slave_router.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_slave_router.sv
// Wishbone address router: fans one upstream master out to NSLV slaves, serves a
// local status register, and turns slave-ack timeouts and unmapped accesses into error acks.

module wb_slave_router_chk #(
   parameter int NSLV = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NSLV-1:0] cyc,
   input  logic [NSLV-1:0] stb,
   input  logic            ack,
   input  logic            irq
);
   a_stb_onehot:   assert property (@(posedge clk) disable iff (rst) $onehot0(stb));
   a_cyc_eq_stb:   assert property (@(posedge clk) disable iff (rst) cyc == stb);
   a_ack_pulse:    assert property (@(posedge clk) disable iff (rst) ack |=> !ack);
   a_irq_with_ack: assert property (@(posedge clk) disable iff (rst) irq |-> ack);
endmodule

module wb_slave_router #(
   parameter int          NSLV     = 4,
   parameter int          TIMEOUT  = 255,
   parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
   input  logic               wb_clk_i,
   input  logic               wb_rst_i,
   input  logic               wbs_cyc_i,
   input  logic               wbs_stb_i,
   input  logic               wbs_we_i,
   input  logic [3:0]         wbs_sel_i,
   input  logic [31:0]        wbs_adr_i,
   input  logic [31:0]        wbs_dat_i,
   output logic               wbs_ack_o,
   output logic [31:0]        wbs_dat_o,
   output logic [NSLV-1:0]    s_cyc_o,
   output logic [NSLV-1:0]    s_stb_o,
   output logic               s_we_o,
   output logic [3:0]         s_sel_o,
   output logic [19:0]        s_adr_o,
   output logic [31:0]        s_dat_o,
   input  logic [32*NSLV-1:0] s_dat_i,
   input  logic [NSLV-1:0]    s_ack_i,
   output logic               err_irq_o
);
   typedef enum logic [1:0] {IDLE = 2'd0, FWD = 2'd1, ACK = 2'd2} state_t;

   localparam logic [7:0] WAIT_LAST  = 8'(TIMEOUT - 1);
   localparam logic [7:0] REGION     = 8'h30;
   localparam logic [3:0] STATUS_IDX = 4'hF;

   state_t          state_r;
   logic [NSLV-1:0] s_stb_r;
   logic            s_we_r;
   logic [3:0]      s_sel_r;
   logic [19:0]     s_adr_r;
   logic [31:0]     s_dat_r;
   logic [7:0]      wait_cnt_r;
   logic            wbs_ack_r;
   logic [31:0]     wbs_dat_r;
   logic            err_irq_r;
   logic [7:0]      to_cnt_r;
   logic            unm_seen_r;
   logic            to_seen_r;

   logic            req_s;
   logic            in_region_s;
   logic            is_slave_s;
   logic            is_status_s;
   logic            is_unmapped_s;
   logic [NSLV-1:0] req_onehot_s;
   logic            sel_ack_s;
   logic [31:0]     sel_dat_s;
   logic            fwd_ack_s;
   logic            timeout_s;
   logic            unm_ev_s;
   logic            stat_clr_s;
   logic [7:0]      to_cnt_base_s;
   logic            unm_seen_base_s;
   logic            to_seen_base_s;
   logic [7:0]      to_cnt_nxt_s;
   logic            unm_seen_nxt_s;
   logic            to_seen_nxt_s;
   logic [31:0]     status_s;

   // Address decode of the current upstream request
   always_comb begin
      req_s         = wbs_cyc_i & wbs_stb_i;
      in_region_s   = (wbs_adr_i[31:24] == REGION);
      is_slave_s    = in_region_s && ({28'd0, wbs_adr_i[23:20]} < 32'(NSLV));
      is_status_s   = in_region_s && (wbs_adr_i[23:20] == STATUS_IDX);
      is_unmapped_s = !is_slave_s && !is_status_s;
      for (int i = 0; i < NSLV; i++) begin
         req_onehot_s[i] = ({28'd0, wbs_adr_i[23:20]} == 32'(i));
      end
   end

   // Response of the strobed slave; the one-hot strobe masks every other slave's ack and data
   always_comb begin
      sel_ack_s = |(s_ack_i & s_stb_r);
      sel_dat_s = 32'd0;
      for (int i = 0; i < NSLV; i++) begin
         sel_dat_s = sel_dat_s | (s_dat_i[32*i +: 32] & {32{s_stb_r[i]}});
      end
   end

   // Transaction events; an upstream abort outranks a slave ack, which outranks the timeout
   always_comb begin
      fwd_ack_s  = (state_r == FWD) && wbs_cyc_i && sel_ack_s;
      timeout_s  = (state_r == FWD) && wbs_cyc_i && !sel_ack_s && (wait_cnt_r == WAIT_LAST);
      unm_ev_s   = (state_r == IDLE) && req_s && is_unmapped_s;
      stat_clr_s = (state_r == IDLE) && req_s && is_status_s && wbs_we_i;
   end

   // Status next value: a write-clear lands first, then this cycle's error events on top
   always_comb begin
      if (stat_clr_s) begin
         to_cnt_base_s   = 8'd0;
         unm_seen_base_s = 1'b0;
         to_seen_base_s  = 1'b0;
      end else begin
         to_cnt_base_s   = to_cnt_r;
         unm_seen_base_s = unm_seen_r;
         to_seen_base_s  = to_seen_r;
      end
      if (timeout_s && (to_cnt_base_s != 8'hFF)) begin
         to_cnt_nxt_s = to_cnt_base_s + 8'd1;
      end else begin
         to_cnt_nxt_s = to_cnt_base_s;
      end
      unm_seen_nxt_s = unm_seen_base_s | unm_ev_s;
      to_seen_nxt_s  = to_seen_base_s | timeout_s;
      status_s       = {22'd0, to_seen_r, unm_seen_r, to_cnt_r};
   end

   // Status register
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         to_cnt_r   <= 8'd0;
         unm_seen_r <= 1'b0;
         to_seen_r  <= 1'b0;
      end else begin
         to_cnt_r   <= to_cnt_nxt_s;
         unm_seen_r <= unm_seen_nxt_s;
         to_seen_r  <= to_seen_nxt_s;
      end
   end

   // Routing FSM with registered upstream response and slave request
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_r    <= IDLE;
         s_stb_r    <= '0;
         s_we_r     <= 1'b0;
         s_sel_r    <= 4'd0;
         s_adr_r    <= 20'd0;
         s_dat_r    <= 32'd0;
         wait_cnt_r <= 8'd0;
         wbs_ack_r  <= 1'b0;
         wbs_dat_r  <= 32'd0;
         err_irq_r  <= 1'b0;
      end else begin
         wbs_ack_r <= 1'b0;
         err_irq_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (req_s && is_slave_s) begin
                  s_stb_r    <= req_onehot_s;
                  s_we_r     <= wbs_we_i;
                  s_sel_r    <= wbs_sel_i;
                  s_adr_r    <= wbs_adr_i[19:0];
                  s_dat_r    <= wbs_dat_i;
                  wait_cnt_r <= 8'd0;
                  state_r    <= FWD;
               end else if (req_s) begin
                  // Status reads see the value before any clear issued by this same access
                  wbs_dat_r <= is_status_s ? status_s : ERR_DATA;
                  wbs_ack_r <= 1'b1;
                  err_irq_r <= unm_ev_s;
                  state_r   <= ACK;
               end else begin
                  state_r <= IDLE;
               end
            end
            FWD: begin
               if (!wbs_cyc_i) begin
                  s_stb_r <= '0;
                  state_r <= IDLE;
               end else if (fwd_ack_s) begin
                  s_stb_r   <= '0;
                  wbs_dat_r <= sel_dat_s;
                  wbs_ack_r <= 1'b1;
                  state_r   <= ACK;
               end else if (timeout_s) begin
                  s_stb_r   <= '0;
                  wbs_dat_r <= ERR_DATA;
                  wbs_ack_r <= 1'b1;
                  err_irq_r <= 1'b1;
                  state_r   <= ACK;
               end else begin
                  wait_cnt_r <= wait_cnt_r + 8'd1;
               end
            end
            ACK: begin
               state_r <= IDLE;
            end
            default: begin
               s_stb_r <= '0;
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign wbs_ack_o = wbs_ack_r;
   assign wbs_dat_o = wbs_dat_r;
   assign s_cyc_o   = s_stb_r;
   assign s_stb_o   = s_stb_r;
   assign s_we_o    = s_we_r;
   assign s_sel_o   = s_sel_r;
   assign s_adr_o   = s_adr_r;
   assign s_dat_o   = s_dat_r;
   assign err_irq_o = err_irq_r;

   wb_slave_router_chk #(.NSLV(NSLV)) u_chk (
      .clk (wb_clk_i),
      .rst (wb_rst_i),
      .cyc (s_cyc_o),
      .stb (s_stb_o),
      .ack (wbs_ack_o),
      .irq (err_irq_o)
   );
endmodule

// File: tb/tb_wb_slave_router.sv
// Bench for wb_slave_router: transaction-level model of routing, timeout and status rules,
// a per-cycle compare process, and literal pins on the headline scenarios.

module tb_wb_slave_router;
   localparam int          NSLV     = 4;
   localparam int          TIMEOUT  = 8;
   localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

   logic               clk = 1'b0;
   logic               wb_rst_i = 1'b1;
   logic               wbs_cyc_i = 1'b0;
   logic               wbs_stb_i = 1'b0;
   logic               wbs_we_i = 1'b0;
   logic [3:0]         wbs_sel_i = 4'd0;
   logic [31:0]        wbs_adr_i = 32'd0;
   logic [31:0]        wbs_dat_i = 32'd0;
   logic               wbs_ack_o;
   logic [31:0]        wbs_dat_o;
   logic [NSLV-1:0]    s_cyc_o;
   logic [NSLV-1:0]    s_stb_o;
   logic               s_we_o;
   logic [3:0]         s_sel_o;
   logic [19:0]        s_adr_o;
   logic [31:0]        s_dat_o;
   logic [32*NSLV-1:0] s_dat_i = '0;
   logic [NSLV-1:0]    s_ack_i = '0;
   logic               err_irq_o;

   wb_slave_router #(.NSLV(NSLV), .TIMEOUT(TIMEOUT), .ERR_DATA(ERR_DATA)) dut (
      .wb_clk_i  (clk),
      .wb_rst_i  (wb_rst_i),
      .wbs_cyc_i (wbs_cyc_i),
      .wbs_stb_i (wbs_stb_i),
      .wbs_we_i  (wbs_we_i),
      .wbs_sel_i (wbs_sel_i),
      .wbs_adr_i (wbs_adr_i),
      .wbs_dat_i (wbs_dat_i),
      .wbs_ack_o (wbs_ack_o),
      .wbs_dat_o (wbs_dat_o),
      .s_cyc_o   (s_cyc_o),
      .s_stb_o   (s_stb_o),
      .s_we_o    (s_we_o),
      .s_sel_o   (s_sel_o),
      .s_adr_o   (s_adr_o),
      .s_dat_o   (s_dat_o),
      .s_dat_i   (s_dat_i),
      .s_ack_i   (s_ack_i),
      .err_irq_o (err_irq_o)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Expected outputs after the next rising edge
   logic            exp_ack = 1'b0;
   logic            exp_irq = 1'b0;
   logic [NSLV-1:0] exp_stb = '0;
   logic [31:0]     exp_dat = 32'd0;
   logic            exp_dat_chk = 1'b0;
   logic            exp_we = 1'b0;
   logic [3:0]      exp_sel = 4'd0;
   logic [19:0]     exp_adr = 20'd0;
   logic [31:0]     exp_wdat = 32'd0;

   // Status register model
   int m_to_cnt = 0;
   bit m_unm = 1'b0;
   bit m_tos = 1'b0;

   // Per-transaction observations
   int          t_steps;
   int          t_stb_cyc;
   int          t_ack_cyc;
   int          t_irq_cyc;
   logic [3:0]  t_stb_first;
   logic [19:0] t_adr_first;
   logic [31:0] t_rdat;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] m_status();
      return {22'd0, m_tos, m_unm, 8'(m_to_cnt)};
   endfunction

   always @(posedge clk) begin
      #2;
      chk("ack", 32'(wbs_ack_o), 32'(exp_ack));
      chk("irq", 32'(err_irq_o), 32'(exp_irq));
      chk("stb", 32'(s_stb_o), 32'(exp_stb));
      chk("cyc", 32'(s_cyc_o), 32'(exp_stb));
      if (exp_ack && exp_dat_chk) chk("rdata", wbs_dat_o, exp_dat);
      if (exp_stb != '0) begin
         chk("s_we", 32'(s_we_o), 32'(exp_we));
         chk("s_sel", 32'(s_sel_o), 32'(exp_sel));
         chk("s_adr", 32'(s_adr_o), 32'(exp_adr));
         chk("s_dat", s_dat_o, exp_wdat);
      end
   end

   task automatic step();
      @(negedge clk);
      if (t_steps == 0) begin
         t_stb_first = s_stb_o;
         t_adr_first = s_adr_o;
      end
      t_steps++;
      if (s_stb_o != '0) t_stb_cyc++;
      if (wbs_ack_o) begin
         t_ack_cyc++;
         t_rdat = wbs_dat_o;
      end
      if (err_irq_o) t_irq_cyc++;
   endtask

   // ack_at / abort_at / rst_at count cycles of FWD (0 = never)
   task automatic xfer(input logic [31:0] adr, input logic we, input logic [31:0] wdat,
                       input logic [3:0] sel, input int ack_at, input logic [31:0] sdat,
                       input int abort_at, input int rst_at);
      logic [3:0] idx;
      bit slave, stat_acc, done, aborted;
      idx      = adr[23:20];
      slave    = (adr[31:24] == 8'h30) && (int'(idx) < NSLV);
      stat_acc = (adr[31:24] == 8'h30) && (idx == 4'hF);
      t_steps = 0; t_stb_cyc = 0; t_ack_cyc = 0; t_irq_cyc = 0; t_rdat = 32'hXXXX_XXXX;
      wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
      wbs_sel_i = sel; wbs_adr_i = adr; wbs_dat_i = wdat;
      s_dat_i = {NSLV{32'h5A5A_0000}};
      if (slave) begin
         exp_stb = '0; exp_stb[idx] = 1'b1;
         exp_we = we; exp_sel = sel; exp_adr = adr[19:0]; exp_wdat = wdat;
         step();
         done = 1'b0; aborted = 1'b0;
         for (int k = 1; k <= TIMEOUT && !done; k++) begin
            s_ack_i = '0;
            if (k == 1 && ack_at != 1) s_ack_i = ~exp_stb;
            if (k == rst_at) begin
               wb_rst_i = 1'b1; exp_stb = '0;
               m_to_cnt = 0; m_unm = 1'b0; m_tos = 1'b0; done = 1'b1;
            end else if (k == abort_at) begin
               wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; exp_stb = '0;
               done = 1'b1; aborted = 1'b1;
            end else if (k == ack_at) begin
               s_ack_i[idx] = 1'b1; s_dat_i[32*idx +: 32] = sdat;
               exp_stb = '0; exp_ack = 1'b1; exp_dat = sdat; exp_dat_chk = 1'b1; done = 1'b1;
            end else if (k == TIMEOUT) begin
               exp_stb = '0; exp_ack = 1'b1; exp_irq = 1'b1;
               exp_dat = ERR_DATA; exp_dat_chk = 1'b1;
               if (m_to_cnt < 255) m_to_cnt++;
               m_tos = 1'b1; done = 1'b1;
            end
            step();
         end
         wb_rst_i = 1'b0; s_ack_i = '0; wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
         exp_ack = 1'b0; exp_irq = 1'b0;
         if (aborted) begin
            s_ack_i[idx] = 1'b1;
            step();
            s_ack_i = '0;
         end
         step();
      end else begin
         s_ack_i     = '1;
         exp_ack     = 1'b1;
         exp_irq     = !stat_acc;
         exp_dat     = stat_acc ? m_status() : ERR_DATA;
         exp_dat_chk = !(stat_acc && we);
         if (stat_acc && we) begin
            m_to_cnt = 0; m_unm = 1'b0; m_tos = 1'b0;
         end else if (!stat_acc) begin
            m_unm = 1'b1;
         end
         step();
         s_ack_i = '0; wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
         exp_ack = 1'b0; exp_irq = 1'b0;
         step();
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish by %0t", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      repeat (2) @(negedge clk);
      chk("reset_dat", wbs_dat_o, 32'h0);
      wb_rst_i = 1'b0;
      @(negedge clk);

      // Slave 1 read, ack on third forward cycle
      xfer(32'h3010_0040, 1'b0, 32'h0, 4'hF, 3, 32'h1234_5678, 0, 0);
      chk("rd1_data", t_rdat, 32'h1234_5678);
      chk("rd1_adr", 32'(t_adr_first), 32'h0000_0040);
      chk("rd1_stb", 32'(t_stb_first), 32'h2);
      chk("rd1_acks", t_ack_cyc, 1);
      chk("rd1_irq", t_irq_cyc, 0);

      // Slave 2 write, immediate ack
      xfer(32'h3020_0000, 1'b1, 32'hA5A5_A5A5, 4'b0011, 1, 32'h0, 0, 0);
      chk("wr2_stb", 32'(t_stb_first), 32'h4);
      chk("wr2_acks", t_ack_cyc, 1);

      // Slave 3 never acks
      xfer(32'h3030_0000, 1'b0, 32'h0, 4'hF, 0, 32'h0, 0, 0);
      chk("to_stb_cycles", t_stb_cyc, 8);
      chk("to_data", t_rdat, 32'hDEAD_BEEF);
      chk("to_irq", t_irq_cyc, 1);
      xfer(32'h30F0_0000, 1'b0, 32'h0, 4'hF, 0, 32'h0, 0, 0);
      chk("status_after_to", t_rdat, 32'h0000_0201);

      // Unmapped: wrong region, idx above NSLV, idx equal to NSLV
      xfer(32'h4000_0000, 1'b0, 32'h0, 4'hF, 0, 32'h0, 0, 0);
      chk("unm1_data", t_rdat, 32'hDEAD_BEEF);
      chk("unm1_stb", t_stb_cyc, 0);
      chk("unm1_irq", t_irq_cyc, 1);
      xfer(32'h3050_0000, 1'b0, 32'h0, 4'hF, 0, 32'h0, 0, 0);
      xfer(32'h3040_0000, 1'b1, 32'h1111_2222, 4'hF, 0, 32'h0, 0, 0);
      chk("unm3_data", t_rdat, 32'hDEAD_BEEF);
      xfer(32'h30F0_0000, 1'b0, 32'h0, 4'hF, 0, 32'h0, 0, 0);
      chk("status_after_unm", t_rdat, 32'h0000_0301);
      xfer(32'h30F0_0000, 1'b1, 32'hFFFF_FFFF, 4'hF, 0, 32'h0, 0, 0);
      xfer(32'h30F0_0000, 1'b0, 32'h0, 4'hF, 0, 32'h0, 0, 0);
      chk("status_cleared", t_rdat, 32'h0);

      // Ack on the last cycle before timeout wins
      xfer(32'h3000_0010, 1'b0, 32'h0, 4'h1, TIMEOUT, 32'hCAFE_F00D, 0, 0);
      chk("late_ok_data", t_rdat, 32'hCAFE_F00D);
      chk("late_ok_irq", t_irq_cyc, 0);

      // Reset two cycles into FWD, then a normal request
      xfer(32'h3010_0000, 1'b0, 32'h0, 4'hF, 0, 32'h0, 0, 2);
      chk("rst_acks", t_ack_cyc, 0);
      chk("rst_dat", wbs_dat_o, 32'h0);
      xfer(32'h3010_0004, 1'b0, 32'h0, 4'hF, 2, 32'h0BAD_CAFE, 0, 0);
      chk("post_rst_data", t_rdat, 32'h0BAD_CAFE);

      // Abort during FWD with late slave ack
      xfer(32'h3020_0008, 1'b0, 32'h0, 4'hF, 0, 32'h0, 2, 0);
      chk("abort_acks", t_ack_cyc, 0);
      xfer(32'h30F0_0000, 1'b0, 32'h0, 4'hF, 0, 32'h0, 0, 0);
      chk("status_after_abort", t_rdat, 32'h0);

      // Timeout counter saturation
      for (int n = 0; n < 256; n++) begin
         xfer(32'h3030_0000, 1'b0, 32'h0, 4'hF, 0, 32'h0, 0, 0);
      end
      xfer(32'h30F0_0000, 1'b0, 32'h0, 4'hF, 0, 32'h0, 0, 0);
      chk("status_saturated", t_rdat, 32'h0000_02FF);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
